// File: rtl/udp_tx_mux_pkg.sv
// Shared types and width helpers for the UDP transmit scheduler.
// Imported by udp_rr_arbiter and udp_tx_mux.
package udp_tx_mux_pkg;

    typedef enum logic [2:0] {IDLE, ARB, START, SEND, GAP} state_t;

    localparam int BYTE_NUM_W = 16;
    localparam int DATA_W     = 32;
    localparam int MAC_W      = 48;
    localparam int IP_W       = 32;
    localparam int PORT_W     = 16;

    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a down-counter that must hold values up to max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/udp_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Produces a one-hot grant, its index and a valid flag.
module udp_rr_arbiter
    import udp_tx_mux_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int IDX_W  = 2
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [CH_NUM-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Walk offsets from the far end so the closest request to ptr is written last.
    always_comb begin : pick
        int pos;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int off = CH_NUM - 1; off >= 0; off--) begin
            pos = (int'(ptr) + off) % CH_NUM;
            if (req[pos[IDX_W-1:0]]) begin
                grant                 = '0;
                grant[pos[IDX_W-1:0]] = 1'b1;
                idx                   = pos[IDX_W-1:0];
                valid                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_mux.sv
// N-channel round-robin scheduler in front of a single udp_send engine, with gap and watchdog.
// Optional per-channel done/error counters when UDP_TX_MUX_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for any ch_start_en
// ARB   | pick winner, latch its header fields, reject zero-length packets
// START | one-cycle tx_start_en to udp_send, grant held
// SEND  | word handshake routed to granted channel, watchdog running
// GAP   | enforced idle after packet end, grant cleared
module udp_tx_mux
    import udp_tx_mux_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int GAP_CYC     = 12
) (
    input  logic                       eth_txc,
    input  logic                       rst_n,
    input  logic [CH_NUM-1:0]          ch_start_en,
    input  logic [CH_NUM*BYTE_NUM_W-1:0] ch_byte_num,
    input  logic [CH_NUM*DATA_W-1:0]   ch_data,
    input  logic [CH_NUM*MAC_W-1:0]    ch_dest_mac,
    input  logic [CH_NUM*IP_W-1:0]     ch_dest_ip,
    input  logic [CH_NUM*PORT_W-1:0]   ch_dest_port,
    output logic [CH_NUM-1:0]          ch_req,
    output logic [CH_NUM-1:0]          ch_grant,
    output logic [CH_NUM-1:0]          ch_done,
    output logic [CH_NUM-1:0]          ch_err,
    output logic                       tx_start_en,
    output logic [BYTE_NUM_W-1:0]      tx_byte_num,
    output logic [DATA_W-1:0]          tx_data,
    output logic [MAC_W-1:0]           pc_mac_addr,
    output logic [IP_W-1:0]            pc_ip_addr,
    output logic [PORT_W-1:0]          pc_udp_port,
`ifdef UDP_TX_MUX_STATS_EN
    output logic [CH_NUM*16-1:0]       ch_pkt_cnt,
    output logic [CH_NUM*8-1:0]        ch_err_cnt,
`endif
    input  logic                       tx_req,
    input  logic                       tx_pkg_done
);

    localparam int IDX_W = ch_idx_w(CH_NUM);
    localparam int WD_W  = cnt_w(TIMEOUT_CYC);
    localparam int GAP_W = cnt_w(GAP_CYC);
    // Loaded one short so the abort lands TIMEOUT_CYC cycles after the start pulse cycle.
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [WD_W-1:0]     wd_cnt;
    logic [GAP_W-1:0]    gap_cnt;

    logic [CH_NUM-1:0]   arb_onehot;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [BYTE_NUM_W-1:0] sel_byte_num;
    logic [MAC_W-1:0]    sel_mac;
    logic [IP_W-1:0]     sel_ip;
    logic [PORT_W-1:0]   sel_port;

    udp_rr_arbiter #(.CH_NUM(CH_NUM), .IDX_W(IDX_W)) u_arb (
        .req   (ch_start_en),
        .ptr   (rr_ptr),
        .grant (arb_onehot),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_byte_num = '0;
        sel_mac      = '0;
        sel_ip       = '0;
        sel_port     = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (arb_onehot[i]) begin
                sel_byte_num = sel_byte_num | ch_byte_num[i*BYTE_NUM_W +: BYTE_NUM_W];
                sel_mac      = sel_mac      | ch_dest_mac[i*MAC_W +: MAC_W];
                sel_ip       = sel_ip       | ch_dest_ip[i*IP_W +: IP_W];
                sel_port     = sel_port     | ch_dest_port[i*PORT_W +: PORT_W];
            end
        end
    end

    // Grant is one-hot, so an AND-OR mux gives zero whenever nothing is granted.
    always_comb begin
        tx_data = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            tx_data = tx_data | (ch_data[i*DATA_W +: DATA_W] & {DATA_W{ch_grant[i]}});
        end
    end

    assign ch_req = ch_grant & {CH_NUM{tx_req}};

    always_ff @(posedge eth_txc) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            ch_grant    <= '0;
            ch_done     <= '0;
            ch_err      <= '0;
            tx_start_en <= 1'b0;
            tx_byte_num <= '0;
            pc_mac_addr <= '0;
            pc_ip_addr  <= '0;
            pc_udp_port <= '0;
        end else begin
            tx_start_en <= 1'b0;
            ch_done     <= '0;
            ch_err      <= '0;
            case (state)
                IDLE: begin
                    if (|ch_start_en) state <= ARB;
                end
                ARB: begin
                    if (arb_valid) begin
                        tx_byte_num <= sel_byte_num;
                        pc_mac_addr <= sel_mac;
                        pc_ip_addr  <= sel_ip;
                        pc_udp_port <= sel_port;
                        rr_ptr      <= (arb_idx == IDX_W'(CH_NUM - 1)) ? '0 : arb_idx + 1'b1;
                        if (sel_byte_num == '0) begin
                            ch_err  <= arb_onehot;
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end else begin
                            tx_start_en <= 1'b1;
                            ch_grant    <= arb_onehot;
                            state       <= START;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    wd_cnt <= WD_LOAD;
                    state  <= SEND;
                end
                SEND: begin
                    if (tx_pkg_done) begin
                        ch_done  <= ch_grant;
                        ch_grant <= '0;
                        gap_cnt  <= GAP_LOAD;
                        state    <= GAP;
                    end else if (wd_cnt == '0) begin
                        ch_err   <= ch_grant;
                        ch_grant <= '0;
                        gap_cnt  <= GAP_LOAD;
                        state    <= GAP;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UDP_TX_MUX_STATS_EN
    always_ff @(posedge eth_txc) begin
        if (!rst_n) begin
            ch_pkt_cnt <= '0;
            ch_err_cnt <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (ch_done[i]) ch_pkt_cnt[i*16 +: 16] <= ch_pkt_cnt[i*16 +: 16] + 16'd1;
                if (ch_err[i])  ch_err_cnt[i*8 +: 8]   <= ch_err_cnt[i*8 +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_udp_tx_mux.sv
// Directed bench for udp_tx_mux (CH_NUM=4, TIMEOUT_CYC=100, GAP_CYC=12).
// Counter checks are included when UDP_TX_MUX_STATS_EN is defined.
module tb_udp_tx_mux;

    localparam int CH_NUM = 4;

    logic                   eth_txc = 1'b0;
    logic                   rst_n;
    logic [CH_NUM-1:0]      ch_start_en;
    logic [CH_NUM*16-1:0]   ch_byte_num;
    logic [CH_NUM*32-1:0]   ch_data;
    logic [CH_NUM*48-1:0]   ch_dest_mac;
    logic [CH_NUM*32-1:0]   ch_dest_ip;
    logic [CH_NUM*16-1:0]   ch_dest_port;
    logic [CH_NUM-1:0]      ch_req;
    logic [CH_NUM-1:0]      ch_grant;
    logic [CH_NUM-1:0]      ch_done;
    logic [CH_NUM-1:0]      ch_err;
    logic                   tx_start_en;
    logic [15:0]            tx_byte_num;
    logic [31:0]            tx_data;
    logic [47:0]            pc_mac_addr;
    logic [31:0]            pc_ip_addr;
    logic [15:0]            pc_udp_port;
    logic                   tx_req;
    logic                   tx_pkg_done;
`ifdef UDP_TX_MUX_STATS_EN
    logic [CH_NUM*16-1:0]   ch_pkt_cnt;
    logic [CH_NUM*8-1:0]    ch_err_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    logic saw_start;

    always #4 eth_txc = ~eth_txc;

    udp_tx_mux #(.CH_NUM(CH_NUM), .TIMEOUT_CYC(100), .GAP_CYC(12)) dut (
        .eth_txc      (eth_txc),
        .rst_n        (rst_n),
        .ch_start_en  (ch_start_en),
        .ch_byte_num  (ch_byte_num),
        .ch_data      (ch_data),
        .ch_dest_mac  (ch_dest_mac),
        .ch_dest_ip   (ch_dest_ip),
        .ch_dest_port (ch_dest_port),
        .ch_req       (ch_req),
        .ch_grant     (ch_grant),
        .ch_done      (ch_done),
        .ch_err       (ch_err),
        .tx_start_en  (tx_start_en),
        .tx_byte_num  (tx_byte_num),
        .tx_data      (tx_data),
        .pc_mac_addr  (pc_mac_addr),
        .pc_ip_addr   (pc_ip_addr),
        .pc_udp_port  (pc_udp_port),
`ifdef UDP_TX_MUX_STATS_EN
        .ch_pkt_cnt   (ch_pkt_cnt),
        .ch_err_cnt   (ch_err_cnt),
`endif
        .tx_req       (tx_req),
        .tx_pkg_done  (tx_pkg_done)
    );

    function automatic logic [47:0] mac_of(input int c);
        return 48'h0200_0000_0010 + 48'(c);
    endfunction

    function automatic logic [15:0] port_of(input int c);
        return 16'd5000 + 16'(c);
    endfunction

    function automatic logic [31:0] data_of(input int k, input int c);
        return 32'hD000_0000 + 32'(k * 16 + c);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge eth_txc);
        #1;
    endtask

    task automatic wait_start(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start_en && n < budget);
        chk("start_seen", 64'(tx_start_en), 64'd1);
    endtask

    task automatic wait_err(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (tx_start_en) saw_start = 1'b1;
        end while (ch_err == '0 && n < budget);
        chk("err_seen", 64'(|ch_err), 64'd1);
    endtask

    task automatic finish_pkt(input int c);
        tick();
        tx_pkg_done = 1'b1;
        tick();
        tx_pkg_done = 1'b0;
        chk("done_pulse", 64'(ch_done), 64'(4'b0001 << c));
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int order [5];
        logic [5:0] pat;
        order = '{0, 1, 2, 3, 0};
        pat   = 6'b101101;

        rst_n = 1'b0;
        ch_start_en = '0;
        tx_req = 1'b0;
        tx_pkg_done = 1'b0;
        saw_start = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            ch_byte_num[i*16 +: 16]  = 16'd64;
            ch_data[i*32 +: 32]      = data_of(0, i);
            ch_dest_mac[i*48 +: 48]  = mac_of(i);
            ch_dest_ip[i*32 +: 32]   = 32'hC0A8_0100 + 32'(i);
            ch_dest_port[i*16 +: 16] = port_of(i);
        end
        idle_wait(3);

        chk("rst_start", 64'(tx_start_en), 64'd0);
        chk("rst_grant", 64'(ch_grant), 64'd0);
        chk("rst_done_err", 64'({ch_done, ch_err}), 64'd0);
        chk("rst_byte_num", 64'(tx_byte_num), 64'd0);
        chk("rst_mac", 64'(pc_mac_addr), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Round robin over all four channels, then wrap to ch0.
        ch_start_en = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(40, cyc);
            chk(k == 0 ? "start_latency" : "gap_to_start", 64'(cyc), k == 0 ? 64'd2 : 64'd14);
            chk("rr_grant", 64'(ch_grant), 64'(4'b0001 << order[k]));
            chk("rr_mac", 64'(pc_mac_addr), 64'(mac_of(order[k])));
            chk("rr_port", 64'(pc_udp_port), 64'(port_of(order[k])));
            chk("rr_byte_num", 64'(tx_byte_num), 64'd64);
            finish_pkt(order[k]);
            chk("grant_clear", 64'(ch_grant), 64'd0);
        end
        ch_start_en = '0;
        idle_wait(13);

        // Word handshake on ch1; request drop after grant must not cancel.
        ch_start_en = 4'b0010;
        wait_start(40, cyc);
        chk("ch1_grant", 64'(ch_grant), 64'b0010);
        ch_start_en = '0;
        tick();
        for (int k = 0; k < 6; k++) begin
            tx_req = pat[k];
            for (int i = 0; i < CH_NUM; i++) ch_data[i*32 +: 32] = data_of(k + 1, i);
            #1;
            chk("ch_req", 64'(ch_req), pat[k] ? 64'b0010 : 64'd0);
            chk("tx_data", 64'(tx_data), 64'(data_of(k + 1, 1)));
            tick();
        end
        tx_req = 1'b0;
        tx_pkg_done = 1'b1;
        tick();
        tx_pkg_done = 1'b0;
        chk("ch1_done", 64'(ch_done), 64'b0010);
        tx_pkg_done = 1'b1;
        tx_req = 1'b1;
        #1;
        chk("gap_ch_req", 64'(ch_req), 64'd0);
        tick();
        tx_pkg_done = 1'b0;
        tx_req = 1'b0;
        chk("done_outside_send", 64'(ch_done), 64'd0);
        idle_wait(12);

        // Zero-length packet on ch2 is rejected without a start pulse.
        ch_byte_num[2*16 +: 16] = 16'd0;
        ch_start_en = 4'b0100;
        saw_start = 1'b0;
        wait_err(40, cyc);
        chk("reject_latency", 64'(cyc), 64'd2);
        chk("reject_err", 64'(ch_err), 64'b0100);
        tick();
        chk("reject_err_1cyc", 64'(ch_err), 64'd0);
        wait_err(40, cyc);
        chk("reject_gap", 64'(cyc + 1), 64'd14);
        chk("reject_no_start", 64'(saw_start), 64'd0);
        ch_start_en = '0;
        ch_byte_num[2*16 +: 16] = 16'd64;
        idle_wait(13);

        // Watchdog abort on ch3 (pointer sits at 3 after the ch2 reject).
        ch_start_en = 4'b1001;
        wait_start(40, cyc);
        chk("wd_grant", 64'(ch_grant), 64'b1000);
        wait_err(200, cyc);
        chk("wd_latency", 64'(cyc), 64'd101);
        chk("wd_err", 64'(ch_err), 64'b1000);
        chk("wd_no_done", 64'(ch_done), 64'd0);
        wait_start(40, cyc);
        chk("wd_next_gap", 64'(cyc), 64'd14);
        chk("wd_next_grant", 64'(ch_grant), 64'b0001);
        ch_start_en = '0;

        // Done in the same cycle the watchdog expires: done wins.
        idle_wait(100);
        tx_pkg_done = 1'b1;
        tick();
        tx_pkg_done = 1'b0;
        chk("tie_done", 64'(ch_done), 64'b0001);
        chk("tie_no_err", 64'(ch_err), 64'd0);
        tick();
        chk("tie_no_late_err", 64'(ch_err), 64'd0);
        idle_wait(12);

        // Reset during SEND abandons the packet and rewinds the pointer.
        ch_start_en = 4'b0010;
        wait_start(40, cyc);
        chk("pre_rst_grant", 64'(ch_grant), 64'b0010);
        tick();
        tx_req = 1'b1;
        ch_start_en = 4'b1111;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_grant_req", 64'({ch_grant, ch_req}), 64'd0);
        chk("mid_rst_tx_data", 64'(tx_data), 64'd0);
        chk("mid_rst_fields", 64'({tx_byte_num, pc_udp_port}), 64'd0);
        chk("mid_rst_mac_ip", 64'(pc_mac_addr) | 64'(pc_ip_addr), 64'd0);
        chk("mid_rst_pulses", 64'({tx_start_en, ch_done, ch_err}), 64'd0);
        tx_req = 1'b0;
        wait_start(40, cyc);
        chk("post_rst_latency", 64'(cyc), 64'd2);
        chk("post_rst_grant", 64'(ch_grant), 64'b0001);
        ch_start_en = '0;
        finish_pkt(0);

`ifdef UDP_TX_MUX_STATS_EN
        ch_start_en = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            wait_start(40, cyc);
            finish_pkt(3);
        end
        wait_start(40, cyc);
        wait_err(200, cyc);
        ch_start_en = '0;
        idle_wait(2);
        chk("stat_pkt3", 64'(ch_pkt_cnt[3*16 +: 16]), 64'd3);
        chk("stat_err3", 64'(ch_err_cnt[3*8 +: 8]), 64'd1);
        chk("stat_pkt0", 64'(ch_pkt_cnt[0 +: 16]), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
